shifter_la_pipe: RTL and testbench
==================================

SHIFTER_LA_PIPE -- requirements
Module: shifter_la_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 48, the signed data word width.
REQ-002 SHALL have parameter MAX_SHIFT, default 15, the largest legal left-shift distance.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, WIDTH bits: signed operand.
REQ-006 SHALL have port in_shift, input, clog2(MAX_SHIFT+1) bits: left-shift distance.
REQ-007 SHALL have port in_valid, input, 1 bit: the operand is presented.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the operand this cycle.
REQ-009 SHALL have port out_data, output, WIDTH bits: shifted result.
REQ-010 SHALL have port out_ovf, output, 1 bit: the result exceeded the signed range.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-013 SHALL compute the arithmetic left shift in_data << in_shift, zero-filling the LSBs; this is the inverse of the team's arithmetic right shifter.
REQ-014 SHALL be built as clog2(MAX_SHIFT+1) binary stages (distance 1<<i, selected by in_shift[i]), with pipeline registers after stage group A (stages 0..1) and after group B (remaining stages).
REQ-015 SHALL have a latency of exactly 2 cycles from an accepted input (in_valid && in_ready) to out_valid, absent backpressure.
REQ-016 SHALL set out_ovf when any of the top in_shift+1 bits of in_data differ, so that sign information is lost; ovf SHALL accumulate per stage and travel with its data.
REQ-017 SHALL keep each register slot's data, ovf and original sign bit together with its valid bit.
REQ-018 SHALL drive in_ready = !validA || (!validB || out_ready) (a stage advances when the stage after it is empty or advancing); accepting one item per cycle at full throughput.
REQ-019 SHALL hold out_data, out_ovf and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL ignore in_data and in_shift when in_valid is low; a shift of 0 passes in_data unchanged with out_ovf=0.
REQ-021 SHALL allow a simultaneous input accept and output drain in one cycle without bubble or loss.
REQ-022 SHALL never drop or duplicate an item under any in_valid/out_ready pattern.

Reset
REQ-023 SHALL, when rst is high at a clock edge, clear both slot valid bits; out_valid=0, out_data=0, out_ovf=0 and in_ready=1 the following cycle.
REQ-024 SHALL discard in-flight items when rst asserts mid-operation, with no output produced for them afterwards.

Configuration
REQ-025 SHALL use macro SHIFTER_LA_SAT_EN: when defined, an overflowed result SHALL saturate to the maximum positive value (0111...1) for a non-negative input and to the minimum negative value (1000...0) for a negative input.
REQ-026 SHALL, without SHIFTER_LA_SAT_EN, output the wrapped (truncated) shift result; out_ovf SHALL be reported identically in both builds.

Structure
REQ-027 SHALL take the stage-count function (clog2 of MAX_SHIFT+1), the group-A stage count (2) and the saturation constants from the shared shifter package used by the right shifter.
REQ-028 SHALL instantiate one sub-module, shifter_la_stage, containing one shift/mux stage with its ovf contribution, reused by every stage.

Verification (bench uses WIDTH=16, MAX_SHIFT=15)
REQ-029 SHALL check: in_data=0x0003, in_shift=4 -> out_data=0x0030, out_ovf=0, two cycles later.
REQ-030 SHALL check: in_data=0x4000, in_shift=1 -> out_ovf=1; out_data=0x7FFF with SHIFTER_LA_SAT_EN, 0x8000 without.
REQ-031 SHALL check: in_data=0xFFFF, in_shift=15 -> 0x8000, out_ovf=0; in_data=0xC000, in_shift=2 -> out_ovf=1, saturated 0x8000 or wrapped 0x0000.
REQ-032 SHALL check: a stream of 6 back-to-back items with out_ready low for cycles 3-7 -> in_ready=0 once both slots are full, outputs held stable, all 6 results delivered in order.
REQ-033 SHALL check: rst asserted for 1 cycle with 2 items in flight -> out_valid=0 next cycle, neither item ever emitted, and the next accepted item is correct.

Source files
------------

// File: rtl/shifter_la_pipe_pkg.sv
// Shared shifter package: stage-count helper, group-A stage count and
// saturation constants used by the arithmetic left and right shifters.
package shifter_la_pipe_pkg;

    // Number of binary shift stages in pipeline group A.
    localparam int GROUP_A_STAGES = 2;

    // Widest data word the saturation helper can produce.
    localparam int SAT_MAX_WIDTH = 256;

    // Number of binary stages (and shift-control bits) for a maximum
    // distance. At least one stage, so the shift port never has zero width.
    function automatic int stage_count(input int max_shift);
        int n;
        n = $clog2(max_shift + 1);
        if (n < 1) begin
            n = 1;
        end else begin
            n = n;
        end
        return n;
    endfunction

    // Saturation word for a width: 0111...1 for a non-negative operand,
    // 1000...0 for a negative one. Bits above the width are zero.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_word(input logic neg, input int width);
        logic [SAT_MAX_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < SAT_MAX_WIDTH; i++) begin
            if (i == width - 1) begin
                w[i] = neg;
            end else if (i < width - 1) begin
                w[i] = ~neg;
            end else begin
                w[i] = 1'b0;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/shifter_la_stage.sv
// One binary stage of the arithmetic left shifter: optionally shifts by DIST
// and ORs in an overflow flag when the bits shifted out (plus the new sign
// bit) were not all copies of the sign.
module shifter_la_stage #(
    parameter int WIDTH = 48,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_ovf,
    input  logic             shift_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    logic lost_s;

    if (DIST < WIDTH) begin : g_partial
        logic [DIST:0] top_s;
        assign top_s  = in_data[WIDTH-1 -: DIST+1];
        // Sign information survives only if the top DIST+1 bits all agree.
        assign lost_s = !((&top_s) || !(|top_s));
    end else begin : g_full
        // Every bit leaves the word; only a pure sign pattern is harmless.
        assign lost_s = !((&in_data) || !(|in_data));
    end

    // Select shifted or passed-through data and accumulate the overflow flag.
    always_comb begin
        out_data = in_data;
        out_ovf  = in_ovf;
        if (shift_en) begin
            out_data = in_data << DIST;
            out_ovf  = in_ovf | lost_s;
        end else begin
            out_data = in_data;
            out_ovf  = in_ovf;
        end
    end

endmodule

// File: rtl/shifter_la_pipe.sv
// Pipelined arithmetic left shifter with overflow detection and a two-slot
// valid/ready pipeline (register after stage group A, register after group B).
// Build option: define SHIFTER_LA_SAT_EN to saturate overflowed results;
// otherwise the wrapped (truncated) shift result is delivered.
module shifter_la_pipe
    import shifter_la_pipe_pkg::*;
#(
    parameter int WIDTH     = 48,
    parameter int MAX_SHIFT = 15,
    localparam int SHIFT_W  = stage_count(MAX_SHIFT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_ovf,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int NA    = (SHIFT_W < GROUP_A_STAGES) ? SHIFT_W : GROUP_A_STAGES;
    localparam int NB    = SHIFT_W - NA;
    localparam int REM_W = (NB > 0) ? NB : 1;
`ifdef SHIFTER_LA_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Combinational stage chains for both groups.
    logic [WIDTH-1:0] a_data_s [0:NA];
    logic             a_ovf_s  [0:NA];
    logic [WIDTH-1:0] b_data_s [0:NB];
    logic             b_ovf_s  [0:NB];

    // Slot A: partially shifted word, its overflow, original sign and the
    // shift bits still to be applied by group B.
    logic             a_valid_q, a_valid_d;
    logic [WIDTH-1:0] a_data_q,  a_data_d;
    logic             a_ovf_q,   a_ovf_d;
    logic             a_sign_q,  a_sign_d;
    logic [REM_W-1:0] a_shift_q, a_shift_d;

    // Slot B: final result presented on the output.
    logic             b_valid_q, b_valid_d;
    logic [WIDTH-1:0] b_data_q,  b_data_d;
    logic             b_ovf_q,   b_ovf_d;

    logic             adv_a_s, adv_b_s, accept_s;
    logic [WIDTH-1:0] sat_s, res_data_s;

    assign a_data_s[0] = in_data;
    assign a_ovf_s[0]  = 1'b0;
    assign b_data_s[0] = a_data_q;
    assign b_ovf_s[0]  = a_ovf_q;

    for (genvar i = 0; i < NA; i++) begin : g_stage_a
        shifter_la_stage #(.WIDTH(WIDTH), .DIST(1 << i)) u_stage (
            .in_data  (a_data_s[i]),
            .in_ovf   (a_ovf_s[i]),
            .shift_en (in_shift[i]),
            .out_data (a_data_s[i+1]),
            .out_ovf  (a_ovf_s[i+1])
        );
    end

    for (genvar j = 0; j < NB; j++) begin : g_stage_b
        shifter_la_stage #(.WIDTH(WIDTH), .DIST(1 << (NA + j))) u_stage (
            .in_data  (b_data_s[j]),
            .in_ovf   (b_ovf_s[j]),
            .shift_en (a_shift_q[j]),
            .out_data (b_data_s[j+1]),
            .out_ovf  (b_ovf_s[j+1])
        );
    end

    // Saturation value follows the operand's original sign.
    assign sat_s      = WIDTH'(sat_word(a_sign_q, WIDTH));
    assign res_data_s = (SAT_EN && b_ovf_s[NB]) ? sat_s : b_data_s[NB];

    // Handshake: a slot advances when it is empty or its successor advances.
    always_comb begin
        adv_b_s  = !b_valid_q || out_ready;
        adv_a_s  = !a_valid_q || adv_b_s;
        accept_s = in_valid && adv_a_s;
    end

    // Next-state of both slots; payload moves only with a valid item.
    always_comb begin
        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        a_ovf_d   = a_ovf_q;
        a_sign_d  = a_sign_q;
        a_shift_d = a_shift_q;
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        b_ovf_d   = b_ovf_q;
        if (adv_a_s) begin
            a_valid_d = in_valid;
        end else begin
            a_valid_d = a_valid_q;
        end
        if (accept_s) begin
            a_data_d  = a_data_s[NA];
            a_ovf_d   = a_ovf_s[NA];
            a_sign_d  = in_data[WIDTH-1];
            a_shift_d = REM_W'(in_shift >> NA);
        end else begin
            a_data_d  = a_data_q;
            a_ovf_d   = a_ovf_q;
            a_sign_d  = a_sign_q;
            a_shift_d = a_shift_q;
        end
        if (adv_b_s) begin
            b_valid_d = a_valid_q;
        end else begin
            b_valid_d = b_valid_q;
        end
        if (adv_b_s && a_valid_q) begin
            b_data_d = res_data_s;
            b_ovf_d  = b_ovf_s[NB];
        end else begin
            b_data_d = b_data_q;
            b_ovf_d  = b_ovf_q;
        end
    end

    // Pipeline registers with synchronous reset that empties both slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            a_ovf_q   <= 1'b0;
            a_sign_q  <= 1'b0;
            a_shift_q <= '0;
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
            b_ovf_q   <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            a_data_q  <= a_data_d;
            a_ovf_q   <= a_ovf_d;
            a_sign_q  <= a_sign_d;
            a_shift_q <= a_shift_d;
            b_valid_q <= b_valid_d;
            b_data_q  <= b_data_d;
            b_ovf_q   <= b_ovf_d;
        end
    end

    assign in_ready  = adv_a_s;
    assign out_valid = b_valid_q;
    assign out_data  = b_data_q;
    assign out_ovf   = b_ovf_q;

endmodule

// File: tb/tb_shifter_la_pipe.sv
// Self-checking bench for shifter_la_pipe (WIDTH=16, MAX_SHIFT=15), with a
// queue scoreboard fed by an arithmetic reference model.
module tb_shifter_la_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic [3:0]  in_shift = 4'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic [16:0] exp_q [$];
    logic        hold_pending = 1'b0;
    logic [15:0] held_data = 16'h0000;
    logic        held_ovf = 1'b0;
    logic        acc_flag = 1'b0;

    shifter_la_pipe #(.WIDTH(16), .MAX_SHIFT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: multiply the signed value by 2**s and test the signed range.
    function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] s);
        longint      v;
        longint      p;
        logic        o;
        logic [15:0] r;
        v = longint'($signed(d));
        p = v * (longint'(1) << s);
        o = (p > 64'sd32767) || (p < -64'sd32768);
        r = p[15:0];
`ifdef SHIFTER_LA_SAT_EN
        if (o) r = (v < 0) ? 16'h8000 : 16'h7FFF;
`endif
        return {o, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs and record accepts mid-cycle, then step.
    task automatic tick();
        logic [16:0] e;
        @(negedge clk);
        acc_flag = in_valid && in_ready;
        if (hold_pending) begin
            chk("hold_valid", out_valid, 32'd1);
            chk("hold_data", out_data, held_data);
            chk("hold_ovf", out_ovf, held_ovf);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e[15:0]);
                chk("out_ovf", out_ovf, e[16]);
                n_out++;
            end
        end
        hold_pending = out_valid && !out_ready && !rst;
        held_data    = out_data;
        held_ovf     = out_ovf;
        if (acc_flag) exp_q.push_back(model(in_data, in_shift));
        if (rst) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic directed(input string tag, input logic [15:0] d, input logic [3:0] s,
                            input logic [15:0] ed, input logic eo);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_shift  = s;
        tick();
        chk({tag, "_accept"}, acc_flag, 32'd1);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_shift = 4'($urandom);
        chk({tag, "_lat1_valid"}, out_valid, 32'd0);
        tick();
        chk({tag, "_lat2_valid"}, out_valid, 32'd1);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_ovf"}, out_ovf, eo);
        tick();
    endtask

    initial begin
        logic [15:0] sd [6];
        logic [3:0]  ss [6];
        int          idx;
        int          base;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ovf", out_ovf, 32'd0);
        chk("rst_in_ready", in_ready, 32'd1);

        // Directed results
        directed("d_0003_s4", 16'h0003, 4'd4, 16'h0030, 1'b0);
`ifdef SHIFTER_LA_SAT_EN
        directed("d_4000_s1", 16'h4000, 4'd1, 16'h7FFF, 1'b1);
        directed("d_C000_s2", 16'hC000, 4'd2, 16'h8000, 1'b1);
`else
        directed("d_4000_s1", 16'h4000, 4'd1, 16'h8000, 1'b1);
        directed("d_C000_s2", 16'hC000, 4'd2, 16'h0000, 1'b1);
`endif
        directed("d_FFFF_s15", 16'hFFFF, 4'd15, 16'h8000, 1'b0);
        directed("d_A5A5_s0", 16'hA5A5, 4'd0, 16'hA5A5, 1'b0);

        // Six back-to-back items with out_ready low in cycles 3..7
        for (int i = 0; i < 6; i++) begin
            sd[i] = 16'($urandom);
            ss[i] = 4'($urandom_range(0, 15));
        end
        idx  = 0;
        base = n_out;
        for (int c = 0; c < 40 && (n_out - base) < 6; c++) begin
            out_ready = !(c >= 3 && c <= 7);
            if (idx < 6) begin
                in_valid = 1'b1;
                in_data  = sd[idx];
                in_shift = ss[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("stream_in_ready", in_ready, (exp_q.size() == 2 && !out_ready) ? 32'd0 : 32'd1);
            tick();
            if (acc_flag) idx++;
        end
        chk("stream_delivered", n_out - base, 32'd6);
        drain();

        // Reset with two items in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_shift  = 4'd1;
        tick();
        in_data   = 16'h0101;
        in_shift  = 4'd3;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_in_ready", in_ready, 32'd1);
        base      = n_out;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("midrst_no_emit", n_out - base, 32'd0);
        directed("d_after_rst", 16'h0015, 4'd2, 16'h0054, 1'b0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            in_shift  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
